// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out shifter.
// State encoding and default word width used by piso_shifter and its bench.
package piso_pkg;

  localparam int PISO_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_t;

endpackage

// File: rtl/piso_bitcount.sv
// Bit counter for one serialized word: synchronous clear, increment enable,
// terminal count at WIDTH-1. The count saturates there and never wraps.
module piso_bitcount #(
  parameter int WIDTH = 8,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && !tc)
      count <= count + 1'b1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in / serial-out shifter: storage register, IDLE/SHIFT/DONE FSM.
// Define PISO_LSB_FIRST_EN for LSB-first output; default build is MSB-first.
module piso_shifter
  import piso_pkg::*;
#(
  parameter int WIDTH      = PISO_WIDTH_DEF,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  input  logic             Enable_bar,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic             Ser_in,
  output logic             Q_ser,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);

  // Rise/fall delays describe output timing of the original part; the
  // synthesised outputs follow registered state with no added delay.
  if (WIDTH < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_param_err
    $error("piso_shifter: WIDTH must be >= 2 and delays non-negative");
  end

  piso_state_t      state, state_nx;
  logic [WIDTH-1:0] storage;
  logic [WIDTH-1:0] sreg, sreg_nx, shifted;
  logic             out_bit;
  logic             load, cnt_inc, cnt_clr, tc;
  logic             busy_s, done_s;

`ifdef PISO_LSB_FIRST_EN
  assign shifted = {Ser_in, sreg[WIDTH-1:1]};
  assign out_bit = sreg[0];
`else
  assign shifted = {sreg[WIDTH-2:0], Ser_in};
  assign out_bit = sreg[WIDTH-1];
`endif

  // Capture is independent of FSM state; a same-edge Start sees the old value.
  always_ff @(posedge Clk) begin
    if (!Clear_bar)
      storage <= '0;
    else if (!Enable_bar)
      storage <= D;
  end

  always_ff @(posedge Clk) begin
    if (!Clear_bar) begin
      state <= IDLE;
      sreg  <= '0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    load     = 1'b0;
    cnt_inc  = 1'b0;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nx = SHIFT;
          sreg_nx  = storage;
          load     = 1'b1;
        end
      end
      SHIFT: begin
        busy_s  = 1'b1;
        cnt_inc = 1'b1;
        sreg_nx = shifted;
        if (tc) state_nx = DONE;
      end
      DONE: begin
        done_s   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cnt_clr = !Clear_bar || load;

  piso_bitcount #(.WIDTH(WIDTH), .CW(CW)) u_bitcount (
    .clk (Clk),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (tc)
  );

  // Outputs are forced low for as long as Clear_bar is held.
  assign Q_ser = Clear_bar & out_bit;
  assign Busy  = Clear_bar & busy_s;
  assign Done  = Clear_bar & done_s;

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter (WIDTH=8): streams, capture during shift,
// held Start, mid-word clear and same-edge Start/capture.
module tb_piso_shifter;

  logic       Clk = 1'b0;
  logic       Clear_bar = 1'b0;
  logic       Enable_bar = 1'b1;
  logic [7:0] D = 8'h00;
  logic       Start = 1'b0;
  logic       Ser_in = 1'b1;
  logic       Q_ser, Busy, Done;

  int n_chk  = 0;
  int n_pass = 0;

  piso_shifter #(.WIDTH(8), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .Clk        (Clk),
    .Clear_bar  (Clear_bar),
    .Enable_bar (Enable_bar),
    .D          (D),
    .Start      (Start),
    .Ser_in     (Ser_in),
    .Q_ser      (Q_ser),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // i-th bit on the wire for word w
  function automatic logic ebit(input logic [7:0] w, input int i);
`ifdef PISO_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  // Entered in the first SHIFT cycle; leaves in the DONE cycle.
  task automatic word(input string tag, input logic [7:0] w, input bit inject);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), {7'b0, Busy}, 8'd1);
      chk($sformatf("%s_done%0d", tag, i), {7'b0, Done}, 8'd0);
      chk($sformatf("%s_q%0d", tag, i), {7'b0, Q_ser}, {7'b0, ebit(w, i)});
      if (inject && i == 2) begin D = 8'hFF; Enable_bar = 1'b0; end
      if (inject && i == 5) Enable_bar = 1'b1;
      tick();
    end
    chk({tag, "_done"}, {7'b0, Done}, 8'd1);
    chk({tag, "_dbusy"}, {7'b0, Busy}, 8'd0);
    chk({tag, "_fill"}, {7'b0, Q_ser}, 8'd1);  // Ser_in=1 filled the register
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    // Reset, with capture and Start also requested (reset must win)
    D = 8'hAA; Enable_bar = 1'b0; Start = 1'b1;
    tick(); tick();
    chk("rst_busy", {7'b0, Busy}, 8'd0);
    chk("rst_done", {7'b0, Done}, 8'd0);
    chk("rst_q", {7'b0, Q_ser}, 8'd0);
    Enable_bar = 1'b1; Start = 1'b0;
    Clear_bar = 1'b1;
    tick();
    chk("post_rst_busy", {7'b0, Busy}, 8'd0);
    // storage was cleared despite Enable_bar=0 at reset: emits 0x00
    pulse_start();
    word("rstwin", 8'h00, 1'b0);
    tick();

    // Basic word 0xC1
    D = 8'hC1; Enable_bar = 1'b0;
    tick();
    Enable_bar = 1'b1;
    chk("idle_busy", {7'b0, Busy}, 8'd0);
    pulse_start();
    word("c1", 8'hC1, 1'b0);
    tick();
    chk("c1_idle_done", {7'b0, Done}, 8'd0);
    chk("c1_idle_busy", {7'b0, Busy}, 8'd0);
    chk("c1_idle_q", {7'b0, Q_ser}, 8'd1);

    // Capture 0xFF during shift: stream unchanged, next word is 0xFF
    pulse_start();
    word("inj", 8'hC1, 1'b1);
    tick();
    pulse_start();
    word("ff", 8'hFF, 1'b0);
    tick();

    // Start held high throughout
    Start = 1'b1;
    tick();
    word("hold1", 8'hFF, 1'b0);
    tick();
    chk("hold_idle_busy", {7'b0, Busy}, 8'd0);
    chk("hold_idle_done", {7'b0, Done}, 8'd0);
    tick();
    Start = 1'b0;
    word("hold2", 8'hFF, 1'b0);
    tick();

    // Clear at the fourth shift cycle
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_q%0d", i), {7'b0, Q_ser}, 8'd1);
      tick();
    end
    chk("abort_busy4", {7'b0, Busy}, 8'd1);
    Clear_bar = 1'b0;
    tick();
    Clear_bar = 1'b1;
    chk("abort_busy", {7'b0, Busy}, 8'd0);
    chk("abort_q", {7'b0, Q_ser}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("abort_nodone%0d", i), {7'b0, Done}, 8'd0);
      tick();
    end
    pulse_start();
    word("abort_stor", 8'h00, 1'b0);
    tick();

    // Start and capture on the same edge
    D = 8'h0F; Enable_bar = 1'b0;
    tick();
    D = 8'hF0; Start = 1'b1;
    tick();
    Enable_bar = 1'b1; Start = 1'b0;
    word("same_old", 8'h0F, 1'b0);
    tick();
    pulse_start();
    word("same_new", 8'hF0, 1'b0);
    tick();
    chk("end_done", {7'b0, Done}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/piso_shifter.md
PISO_SHIFTER -- requirements
Module: piso_shifter

Interface
- REQ-001: WIDTH, default 8; bits per word, minimum 2.
- REQ-002: DELAY_RISE, default 0; rise delay applied to Q_ser, Busy and Done.
- REQ-003: DELAY_FALL, default 0; fall delay applied to Q_ser, Busy and Done.
- REQ-004: Clk  input  1  the only clock; all state changes on its rising edge.
- REQ-005: Clear_bar  input  1  reset; synchronous, active-low.
- REQ-006: Enable_bar  input  1  active-low capture of D into the storage register.
- REQ-007: D  input  WIDTH  parallel data word.
- REQ-008: Start  input  1  active-high request to serialize the storage register.
- REQ-009: Ser_in  input  1  fill bit shifted into the vacated end of the shift register.
- REQ-010: Q_ser  output  1  serial data out.
- REQ-011: Busy  output  1  high while a word is being shifted out.
- REQ-012: Done  output  1  one-cycle pulse after the last bit.

Function
- REQ-013: Storage register SHALL load D on any edge where Enable_bar=0, in every state, and hold otherwise.
- REQ-014: FSM states SHALL be IDLE, SHIFT and DONE.
- REQ-015: Start=1 in IDLE SHALL copy the pre-edge storage value to the shift register, clear the bit counter and enter SHIFT.
- REQ-016: Start and Enable_bar=0 on the same IDLE edge SHALL load the old storage value into the shift register; D reaches storage only.
- REQ-017: In SHIFT, Q_ser SHALL equal the shift register MSB, so bit WIDTH-1 is valid in the first SHIFT cycle.
- REQ-018: Each SHIFT edge SHALL shift left by one, insert Ser_in at bit 0 and increment the counter.
- REQ-019: The edge where the counter reaches WIDTH-1 SHALL enter DONE, so the word occupies exactly WIDTH SHIFT cycles.
- REQ-020: DONE SHALL last one cycle, assert Done=1 and Busy=0, then return to IDLE.
- REQ-021: Start SHALL be ignored outside IDLE, with no queuing.
- REQ-022: Busy SHALL be 1 exactly in SHIFT; Done SHALL be 1 exactly in DONE.
- REQ-023: Enable_bar=0 during SHIFT SHALL NOT disturb the shift register or the bit stream.
- REQ-024: In IDLE and DONE, Q_ser SHALL hold the current shift-register output bit.
- REQ-025: Counter width SHALL be $clog2(WIDTH); the counter never wraps within a word.

Reset
- REQ-026: Clear_bar=0 at an edge SHALL force IDLE and clear storage, shift register and counter to 0.
- REQ-027: During reset, Q_ser, Busy and Done SHALL be 0.
- REQ-028: Clear_bar SHALL override Enable_bar and Start on the same edge.
- REQ-029: Reset mid-SHIFT SHALL abort the word with no Done pulse.

Configuration
- REQ-030: With PISO_LSB_FIRST_EN defined, the block SHALL shift right, output bit 0 first and insert Ser_in at bit WIDTH-1.
- REQ-031: With PISO_LSB_FIRST_EN undefined, the block SHALL be MSB-first as REQ-017/018; timing SHALL be identical in both modes.

Structure
- REQ-032: Shared package piso_pkg SHALL hold the state typedef (IDLE/SHIFT/DONE) and the default-width constant.
- REQ-033: The bit counter SHALL be the sub-module piso_bitcount, with synchronous clear, increment enable and a terminal-count output.

Verification (WIDTH=8, MSB-first unless noted)
- REQ-034: Clear, capture D=0xC1 with Enable_bar=0, pulse Start -> Q_ser 1,1,0,0,0,0,0,1 over 8 Busy cycles, then Done=1 for one cycle.
- REQ-035: Same run with PISO_LSB_FIRST_EN defined -> Q_ser 1,0,0,0,0,0,1,1.
- REQ-036: Storage=0xC1 and D=0xFF captured during shift -> stream unchanged; next Start emits 0xFF.
- REQ-037: Start held high throughout -> Start ignored during SHIFT and DONE; a new word starts the cycle after DONE.
- REQ-038: Clear_bar=0 at the fourth shift cycle -> next cycle Busy=0, Q_ser=0, no Done, storage=0x00.
- REQ-039: Start and Enable_bar=0 on the same edge (storage 0x0F, D=0xF0) -> emits 0x0F; storage=0xF0 afterwards.
